sprite_blitter: RTL and testbench
=================================

# sprite_blitter

Writer side of the VGA frame buffer. On a start command it copies a rectangular sprite from the sprite ROM into the 640x480, 8-bit (RGB332) frame buffer, one pixel per clock. It clips at screen edges and optionally skips a transparent colour key. It sits between game logic (veggie/blade drawing) and the frame buffer write port; the VGA scan-out side reads the same buffer through `frame_rdAddress`.

## Interface
Parameters:
- `SCREEN_W`, default 640: frame width in pixels.
- `SCREEN_H`, default 480: frame height in pixels.
- `TRANSPARENT`, default 8'hE3: colour key that is never written (magenta in RGB332).

Ports:
- `CLOCK_50`, in, 1: sole clock.
- `Reset`, in, 1: synchronous, active-high.
- `start`, in, 1: blit request; sampled only in IDLE.
- `dst_x`, in, 11: sprite top-left X, two's complement (-1024..1023).
- `dst_y`, in, 11: sprite top-left Y, two's complement.
- `spr_base`, in, 16: sprite ROM address of pixel (0,0).
- `spr_w`, in, 7: sprite width, 0..64.
- `spr_h`, in, 7: sprite height, 0..64.
- `busy`, out, 1: blit in progress.
- `done`, out, 1: one-cycle completion pulse.
- `sprite_rdAddress`, out, 16: ROM read address.
- `sprite_data`, in, 8: ROM data; registered ROM, valid 1 cycle after address.
- `frame_wrAddress`, out, 19: frame buffer address, y*640+x.
- `frame_wrData`, out, 8: pixel to write.
- `frame_we`, out, 1: write strobe.

## Operation
- States: IDLE, FETCH, DRAIN, DONE.
- **IDLE**
  - On `start`, latch `dst_x`, `dst_y`, `spr_base`, `spr_w`, `spr_h`.
  - Go to FETCH, or straight to DONE if `spr_w`==0 or `spr_h`==0. A zero-size blit issues no writes.
- **FETCH**
  - Raster order: sx from 0 to w-1, inner loop; sy from 0 to h-1.
  - A running ROM pointer starts at `spr_base` and increments by 1 each cycle; no multiplier. 16-bit wrap is permitted.
  - After pixel (w-1, h-1), go to DRAIN.
- **DRAIN**: 2 cycles to flush the pipeline, then go to DONE.
- **DONE**: `done`=1 for one cycle, then IDLE.
- **Pipeline per pixel**
  - Coordinates travel with the pixel: px = dst_x + sx and py = dst_y + sy, each 12-bit signed.
  - Write only if 0 <= px < SCREEN_W and 0 <= py < SCREEN_H, and the pixel passes the colour-key test (see Configuration).
  - A clipped or keyed pixel still consumes its cycle, with `frame_we`=0.
- **Address**: `frame_wrAddress` = (py<<9) + (py<<7) + px, computed at 19 bits unsigned from the in-range py and px.
- **`start` outside IDLE**: ignored, not queued.
- **`Reset` at any time**
  - All state returns to IDLE and all outputs go to 0.
  - In-flight pixels are discarded: no further writes and no `done` pulse.

## Timing
- Cycle 0 is the cycle in which `start` is high in IDLE.
- Pixel k (k = sy*w + sx):
  - `sprite_rdAddress` in cycle 1+k.
  - `sprite_data` in cycle 2+k.
  - `frame_we`/`frame_wrAddress`/`frame_wrData` registered in cycle 3+k.
- `busy`=1 in cycles 1 through 2+w*h (FETCH and DRAIN).
- `done`=1 in cycle 3+w*h, with `busy`=0 in that cycle.
- The earliest accepted restart is cycle 4+w*h.
- Zero-size blit: `done` in cycle 1; `busy` never rises.
- Throughput is 1 pixel/clock. Total latency is w*h+3 cycles.
- Reset values: `busy`=0, `done`=0, `frame_we`=0, `sprite_rdAddress`=0, `frame_wrAddress`=0, `frame_wrData`=0.

## Configuration
- `BLIT_TRANSPARENCY_EN` defined: pixels whose `sprite_data` equals `TRANSPARENT` are not written.
- Not defined: every in-bounds pixel is written, including 8'hE3. The `TRANSPARENT` parameter is unused.

## Structure
- Shared package `veggie_pkg` holds:
  - `SCREEN_W` and `SCREEN_H` constants.
  - `pixel_t` (logic [7:0]).
  - `frame_addr_t` (logic [18:0]).
  - The blitter state enum.
- The frame-buffer read side uses the same package.
- One sub-module, `frame_addr_calc`:
  - Registered.
  - Takes px and py (12-bit signed) and produces an in-bounds flag plus `frame_addr_t`.
  - Uses shift-add, 1-cycle latency.

## Test plan
1. **Basic blit**: 4x2 sprite at (10,20), `spr_base`=0, ROM[a]=a. Expect 8 writes at 12810..12813 and 13450..13453 with data 0..7, and `done` in cycle 11.
2. **Colour key**: as test 1, with ROM[2]=8'hE3. With the macro: 7 writes, address 12812 skipped, `done` still in cycle 11. Without the macro: 8 writes, 12812 written with 8'hE3.
3. **Clipping**: 4x4 at (-2,478). Expect exactly 4 writes, at 305920, 305921, 306560, 306561. `busy` holds for 18 cycles.
4. **Ignored start / zero size**: `start` pulsed at cycle 5 of a 4x2 blit produces no extra writes. A blit with `spr_w`=0 gives `done` in cycle 1, no `frame_we`, and `busy` stays 0.
5. **Reset mid-blit**: `Reset` asserted at cycle 6 of a 4x2 blit. `frame_we`=0 from the next cycle, no `done`. A following start blits correctly from pixel 0.

Source files
------------

// File: rtl/veggie_pkg.sv
// Shared types for the veggie frame buffer: screen geometry, pixel/address types, blitter states.
// Both the sprite blitter (write side) and the VGA scan-out (read side) import this package.
package veggie_pkg;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  typedef logic [7:0]  pixel_t;       // RGB332
  typedef logic [18:0] frame_addr_t;  // y*640 + x

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DRAIN,
    ST_DONE
  } blit_state_e;

endpackage

// File: rtl/sprite_blitter_if.sv
// Blit command channel between game logic (master) and the sprite blitter (slave).
interface sprite_blitter_if;

  logic        start;
  logic [10:0] dst_x;
  logic [10:0] dst_y;
  logic [15:0] spr_base;
  logic [6:0]  spr_w;
  logic [6:0]  spr_h;
  logic        busy;
  logic        done;

  modport master (
    output start, dst_x, dst_y, spr_base, spr_w, spr_h,
    input  busy, done
  );

  modport slave (
    input  start, dst_x, dst_y, spr_base, spr_w, spr_h,
    output busy, done
  );

endinterface

// File: rtl/frame_addr_calc.sv
// Registered screen-coordinate check and frame-buffer address (y*640 + x by shift-add), 1-cycle latency.
module frame_addr_calc #(
  parameter int SCREEN_W = veggie_pkg::SCREEN_W,
  parameter int SCREEN_H = veggie_pkg::SCREEN_H
) (
  input  logic                    clk,
  input  logic                    srst,
  input  logic signed [11:0]      px,
  input  logic signed [11:0]      py,
  output logic                    in_bounds,
  output veggie_pkg::frame_addr_t addr
);

  import veggie_pkg::frame_addr_t;

  logic        in_bounds_next;
  frame_addr_t addr_next;

  always_comb begin
    in_bounds_next = 1'b0;
    addr_next      = '0;
    // Sign bit rules out negatives, so the upper-bound compares can be unsigned.
    in_bounds_next = !px[11] && !py[11]
                  && ($unsigned(px) < 12'(SCREEN_W))
                  && ($unsigned(py) < 12'(SCREEN_H));
    addr_next = ({8'd0, py[10:0]} << 9) + ({8'd0, py[10:0]} << 7) + {8'd0, px[10:0]};
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      in_bounds <= 1'b0;
      addr      <= '0;
    end else begin
      in_bounds <= in_bounds_next;
      addr      <= addr_next;
    end
  end

endmodule

// File: rtl/sprite_blitter.sv
// Copies a w x h sprite from the sprite ROM into the frame buffer, one pixel per clock, with edge clipping.
// Define BLIT_TRANSPARENCY_EN to skip pixels equal to the TRANSPARENT colour key.
module sprite_blitter #(
  parameter int          SCREEN_W    = veggie_pkg::SCREEN_W,
  parameter int          SCREEN_H    = veggie_pkg::SCREEN_H,
  parameter logic [7:0]  TRANSPARENT = 8'hE3
) (
  input  logic                  CLOCK_50,
  input  logic                  Reset,
  sprite_blitter_if.slave       cmd,
  output logic [15:0]           sprite_rdAddress,
  input  logic [7:0]            sprite_data,
  output logic [18:0]           frame_wrAddress,
  output logic [7:0]            frame_wrData,
  output logic                  frame_we
);

  import veggie_pkg::pixel_t;
  import veggie_pkg::frame_addr_t;
  import veggie_pkg::blit_state_e;
  import veggie_pkg::ST_IDLE;
  import veggie_pkg::ST_FETCH;
  import veggie_pkg::ST_DRAIN;
  import veggie_pkg::ST_DONE;

`ifdef BLIT_TRANSPARENCY_EN
  localparam logic KEY_EN = 1'b1;
`else
  localparam logic KEY_EN = 1'b0;
`endif

  blit_state_e        state_reg, state_next;
  logic [10:0]        dst_x_reg, dst_y_reg;
  logic [6:0]         w_reg, h_reg;
  logic [6:0]         sx_reg, sy_reg;
  logic [15:0]        rd_ptr_reg;
  logic               drain_cnt_reg;
  logic               last_pix;

  // Stage 1: coordinates of the pixel whose ROM data arrives next cycle.
  logic               valid1_reg;
  logic signed [11:0] px1_reg, py1_reg;

  // Stage 2: write strobe (before clipping) and pixel data, aligned with the address calc output.
  logic               we_pre_reg;
  pixel_t             data_reg;
  logic               in_bounds;
  frame_addr_t        addr_calc;
  logic               key_ok;

  assign last_pix = (sx_reg == w_reg - 7'd1) && (sy_reg == h_reg - 7'd1);
  assign key_ok   = !KEY_EN || (sprite_data != TRANSPARENT);

  always_comb begin
    state_next = state_reg;
    cmd.busy   = 1'b0;
    cmd.done   = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (cmd.start)
          state_next = (cmd.spr_w == 7'd0 || cmd.spr_h == 7'd0) ? ST_DONE : ST_FETCH;
      end
      ST_FETCH: begin
        cmd.busy = 1'b1;
        if (last_pix) state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        cmd.busy = 1'b1;
        if (drain_cnt_reg) state_next = ST_DONE;
      end
      ST_DONE: begin
        cmd.done   = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (Reset) begin
      state_reg     <= ST_IDLE;
      dst_x_reg     <= '0;
      dst_y_reg     <= '0;
      w_reg         <= '0;
      h_reg         <= '0;
      sx_reg        <= '0;
      sy_reg        <= '0;
      rd_ptr_reg    <= '0;
      drain_cnt_reg <= 1'b0;
      valid1_reg    <= 1'b0;
      px1_reg       <= '0;
      py1_reg       <= '0;
      we_pre_reg    <= 1'b0;
      data_reg      <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == ST_IDLE && cmd.start) begin
        dst_x_reg  <= cmd.dst_x;
        dst_y_reg  <= cmd.dst_y;
        w_reg      <= cmd.spr_w;
        h_reg      <= cmd.spr_h;
        rd_ptr_reg <= cmd.spr_base;
        sx_reg     <= '0;
        sy_reg     <= '0;
      end else if (state_reg == ST_FETCH) begin
        // Running pointer instead of sy*w+sx: raster order makes ROM addresses consecutive.
        rd_ptr_reg <= rd_ptr_reg + 16'd1;
        if (sx_reg == w_reg - 7'd1) begin
          sx_reg <= '0;
          sy_reg <= sy_reg + 7'd1;
        end else begin
          sx_reg <= sx_reg + 7'd1;
        end
      end
      drain_cnt_reg <= (state_reg == ST_DRAIN) && !drain_cnt_reg;

      valid1_reg <= (state_reg == ST_FETCH);
      px1_reg    <= {dst_x_reg[10], dst_x_reg} + {5'd0, sx_reg};
      py1_reg    <= {dst_y_reg[10], dst_y_reg} + {5'd0, sy_reg};

      we_pre_reg <= valid1_reg && key_ok;
      data_reg   <= sprite_data;
    end
  end

  frame_addr_calc #(
    .SCREEN_W (SCREEN_W),
    .SCREEN_H (SCREEN_H)
  ) u_addr (
    .clk       (CLOCK_50),
    .srst      (Reset),
    .px        (px1_reg),
    .py        (py1_reg),
    .in_bounds (in_bounds),
    .addr      (addr_calc)
  );

  assign sprite_rdAddress = rd_ptr_reg;
  assign frame_wrAddress  = addr_calc;
  assign frame_wrData     = data_reg;
  assign frame_we         = we_pre_reg && in_bounds;

endmodule

// File: tb/tb_sprite_blitter.sv
// Directed bench for sprite_blitter: cycle-accurate write log per blit compared against hand-computed vectors.
module tb_sprite_blitter;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] sprite_rdAddress;
  logic [7:0]  sprite_data;
  logic [18:0] frame_wrAddress;
  logic [7:0]  frame_wrData;
  logic        frame_we;

  logic [7:0]  rom [0:255];

  int n_vec  = 0;
  int n_miss = 0;

  int wr_addr_q[$];
  int wr_data_q[$];
  int wr_cyc_q[$];
  int done_first, done_cnt, busy_first, busy_last, busy_cnt;

  always #5 clk = ~clk;

  sprite_blitter_if cmd_if ();

  sprite_blitter dut (
    .CLOCK_50         (clk),
    .Reset            (rst),
    .cmd              (cmd_if),
    .sprite_rdAddress (sprite_rdAddress),
    .sprite_data      (sprite_data),
    .frame_wrAddress  (frame_wrAddress),
    .frame_wrData     (frame_wrData),
    .frame_we         (frame_we)
  );

  // Registered sprite ROM: data valid one cycle after the address.
  always @(posedge clk) sprite_data <= rom[sprite_rdAddress[7:0]];

  // Start a blit in cycle 0 and log outputs for cycles 1..ncyc; optional start pulse / reset in a given cycle.
  task automatic run_blit(input logic [10:0] x, input logic [10:0] y, input logic [15:0] base,
                          input logic [6:0] w, input logic [6:0] h,
                          input int ncyc, input int pulse_c, input int reset_c);
    wr_addr_q.delete();
    wr_data_q.delete();
    wr_cyc_q.delete();
    done_first = -1; done_cnt = 0; busy_first = -1; busy_last = -1; busy_cnt = 0;
    cmd_if.dst_x = x; cmd_if.dst_y = y; cmd_if.spr_base = base;
    cmd_if.spr_w = w; cmd_if.spr_h = h; cmd_if.start = 1'b1;
    for (int c = 1; c <= ncyc; c++) begin
      @(posedge clk); #1;
      if (frame_we) begin
        wr_addr_q.push_back(int'(frame_wrAddress));
        wr_data_q.push_back(int'(frame_wrData));
        wr_cyc_q.push_back(c);
      end
      if (cmd_if.done) begin
        if (done_first < 0) done_first = c;
        done_cnt++;
      end
      if (cmd_if.busy) begin
        if (busy_first < 0) busy_first = c;
        busy_last = c;
        busy_cnt++;
      end
      cmd_if.start = (c == pulse_c);
      cmd_if.dst_x = (c == pulse_c) ? x + 11'd100 : x;
      rst = (c == reset_c);
    end
    cmd_if.start = 1'b0;
    $display("blit x=%0d y=%0d base=%h %0dx%0d: %0d writes, done@%0d, busy %0d cycles",
             $signed(x), $signed(y), base, w, h, wr_addr_q.size(), done_first, busy_cnt);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    cmd_if.start = 1'b0;
    cmd_if.dst_x = '0; cmd_if.dst_y = '0; cmd_if.spr_base = '0;
    cmd_if.spr_w = '0; cmd_if.spr_h = '0;
    repeat (3) @(posedge clk);
    #1;
    n_vec++; if (cmd_if.busy !== 1'b0) begin n_miss++; $display("FAIL reset_busy: got %b expected 0", cmd_if.busy); end
    n_vec++; if (cmd_if.done !== 1'b0) begin n_miss++; $display("FAIL reset_done: got %b expected 0", cmd_if.done); end
    n_vec++; if (frame_we !== 1'b0) begin n_miss++; $display("FAIL reset_we: got %b expected 0", frame_we); end
    n_vec++; if (sprite_rdAddress !== 16'd0) begin n_miss++; $display("FAIL reset_rdaddr: got %h expected 0", sprite_rdAddress); end
    n_vec++; if (frame_wrAddress !== 19'd0) begin n_miss++; $display("FAIL reset_wraddr: got %h expected 0", frame_wrAddress); end
    n_vec++; if (frame_wrData !== 8'd0) begin n_miss++; $display("FAIL reset_wrdata: got %h expected 0", frame_wrData); end
    $display("reset: outputs checked");
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    run_blit(11'd10, 11'd20, 16'd0, 7'd4, 7'd2, 14, -1, -1);
    n_vec++; if (wr_addr_q.size() != 8) begin n_miss++; $display("FAIL basic_count: got %0d expected 8", wr_addr_q.size()); end
    for (int k = 0; k < 8 && k < wr_addr_q.size(); k++) begin
      n_vec++;
      if (wr_addr_q[k] != ((k < 4) ? 12810 + k : 13450 + k - 4) || wr_data_q[k] != k || wr_cyc_q[k] != 3 + k) begin
        n_miss++;
        $display("FAIL basic_write[%0d]: got addr %0d data %0d cyc %0d expected addr %0d data %0d cyc %0d",
                 k, wr_addr_q[k], wr_data_q[k], wr_cyc_q[k], (k < 4) ? 12810 + k : 13450 + k - 4, k, 3 + k);
      end
    end
    n_vec++; if (done_first != 11 || done_cnt != 1) begin n_miss++; $display("FAIL basic_done: got cycle %0d count %0d expected cycle 11 count 1", done_first, done_cnt); end
    n_vec++; if (busy_first != 1 || busy_last != 10 || busy_cnt != 10) begin n_miss++; $display("FAIL basic_busy: got %0d..%0d (%0d) expected 1..10 (10)", busy_first, busy_last, busy_cnt); end
  endtask

  task automatic test_colour_key;
    int exp_a[$];
    int exp_d[$];
    rom[2] = 8'hE3;
    for (int k = 0; k < 8; k++) begin
`ifdef BLIT_TRANSPARENCY_EN
      if (k == 2) continue;
`endif
      exp_a.push_back((k < 4) ? 12810 + k : 13450 + k - 4);
      exp_d.push_back((k == 2) ? 8'hE3 : k);
    end
    run_blit(11'd10, 11'd20, 16'd0, 7'd4, 7'd2, 14, -1, -1);
    rom[2] = 8'd2;
    n_vec++; if (wr_addr_q.size() != exp_a.size()) begin n_miss++; $display("FAIL key_count: got %0d expected %0d", wr_addr_q.size(), exp_a.size()); end
    for (int i = 0; i < exp_a.size() && i < wr_addr_q.size(); i++) begin
      n_vec++;
      if (wr_addr_q[i] != exp_a[i] || wr_data_q[i] != exp_d[i]) begin
        n_miss++;
        $display("FAIL key_write[%0d]: got addr %0d data %0h expected addr %0d data %0h", i, wr_addr_q[i], wr_data_q[i], exp_a[i], exp_d[i]);
      end
    end
    n_vec++; if (done_first != 11) begin n_miss++; $display("FAIL key_done: got cycle %0d expected 11", done_first); end
  endtask

  task automatic test_clipping;
    int exp_a[4] = '{305920, 305921, 306560, 306561};
    int exp_d[4] = '{2, 3, 6, 7};
    int exp_c[4] = '{5, 6, 9, 10};
    run_blit(11'h7FE, 11'd478, 16'd0, 7'd4, 7'd4, 22, -1, -1);
    n_vec++; if (wr_addr_q.size() != 4) begin n_miss++; $display("FAIL clip_count: got %0d expected 4", wr_addr_q.size()); end
    for (int i = 0; i < 4 && i < wr_addr_q.size(); i++) begin
      n_vec++;
      if (wr_addr_q[i] != exp_a[i] || wr_data_q[i] != exp_d[i] || wr_cyc_q[i] != exp_c[i]) begin
        n_miss++;
        $display("FAIL clip_write[%0d]: got addr %0d data %0d cyc %0d expected addr %0d data %0d cyc %0d",
                 i, wr_addr_q[i], wr_data_q[i], wr_cyc_q[i], exp_a[i], exp_d[i], exp_c[i]);
      end
    end
    n_vec++; if (busy_cnt != 18 || busy_last != 18) begin n_miss++; $display("FAIL clip_busy: got %0d cycles last %0d expected 18 last 18", busy_cnt, busy_last); end
    n_vec++; if (done_first != 19) begin n_miss++; $display("FAIL clip_done: got cycle %0d expected 19", done_first); end
  endtask

  // Right-edge clip plus 16-bit ROM pointer wrap (FFFE, FFFF, 0000, 0001, 0002).
  task automatic test_edges;
    int exp_d[4] = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    run_blit(11'd636, 11'd0, 16'hFFFE, 7'd5, 7'd1, 10, -1, -1);
    n_vec++; if (wr_addr_q.size() != 4) begin n_miss++; $display("FAIL edge_count: got %0d expected 4", wr_addr_q.size()); end
    for (int i = 0; i < 4 && i < wr_addr_q.size(); i++) begin
      n_vec++;
      if (wr_addr_q[i] != 636 + i || wr_data_q[i] != exp_d[i]) begin
        n_miss++;
        $display("FAIL edge_write[%0d]: got addr %0d data %0h expected addr %0d data %0h", i, wr_addr_q[i], wr_data_q[i], 636 + i, exp_d[i]);
      end
    end
    n_vec++; if (done_first != 8) begin n_miss++; $display("FAIL edge_done: got cycle %0d expected 8", done_first); end
  endtask

  task automatic test_ignored_start;
    run_blit(11'd10, 11'd20, 16'd0, 7'd4, 7'd2, 16, 5, -1);
    n_vec++; if (wr_addr_q.size() != 8) begin n_miss++; $display("FAIL ign_count: got %0d expected 8", wr_addr_q.size()); end
    for (int k = 0; k < 8 && k < wr_addr_q.size(); k++) begin
      n_vec++;
      if (wr_addr_q[k] != ((k < 4) ? 12810 + k : 13450 + k - 4) || wr_data_q[k] != k) begin
        n_miss++;
        $display("FAIL ign_write[%0d]: got addr %0d data %0d expected addr %0d data %0d",
                 k, wr_addr_q[k], wr_data_q[k], (k < 4) ? 12810 + k : 13450 + k - 4, k);
      end
    end
    n_vec++; if (done_first != 11 || done_cnt != 1) begin n_miss++; $display("FAIL ign_done: got cycle %0d count %0d expected cycle 11 count 1", done_first, done_cnt); end
  endtask

  task automatic test_zero_size;
    run_blit(11'd10, 11'd20, 16'd0, 7'd0, 7'd2, 5, -1, -1);
    n_vec++; if (wr_addr_q.size() != 0) begin n_miss++; $display("FAIL zw_writes: got %0d expected 0", wr_addr_q.size()); end
    n_vec++; if (done_first != 1 || done_cnt != 1) begin n_miss++; $display("FAIL zw_done: got cycle %0d count %0d expected cycle 1 count 1", done_first, done_cnt); end
    n_vec++; if (busy_cnt != 0) begin n_miss++; $display("FAIL zw_busy: got %0d cycles expected 0", busy_cnt); end
    run_blit(11'd10, 11'd20, 16'd0, 7'd3, 7'd0, 5, -1, -1);
    n_vec++; if (wr_addr_q.size() != 0 || done_first != 1 || busy_cnt != 0) begin
      n_miss++;
      $display("FAIL zh_blit: got writes %0d done %0d busy %0d expected 0 1 0", wr_addr_q.size(), done_first, busy_cnt);
    end
  endtask

  task automatic test_reset_mid;
    run_blit(11'd10, 11'd20, 16'd0, 7'd4, 7'd2, 14, -1, 6);
    n_vec++; if (wr_addr_q.size() != 4) begin n_miss++; $display("FAIL rmid_count: got %0d expected 4", wr_addr_q.size()); end
    n_vec++; if (wr_cyc_q.size() > 0 && wr_cyc_q[wr_cyc_q.size() - 1] != 6) begin
      n_miss++; $display("FAIL rmid_last: got cycle %0d expected 6", wr_cyc_q[wr_cyc_q.size() - 1]);
    end
    n_vec++; if (done_cnt != 0) begin n_miss++; $display("FAIL rmid_done: got %0d pulses expected 0", done_cnt); end
    n_vec++; if (busy_last != 6) begin n_miss++; $display("FAIL rmid_busy: got last %0d expected 6", busy_last); end
    run_blit(11'd10, 11'd20, 16'd16, 7'd4, 7'd2, 14, -1, -1);
    n_vec++; if (wr_addr_q.size() != 8) begin n_miss++; $display("FAIL rpost_count: got %0d expected 8", wr_addr_q.size()); end
    for (int k = 0; k < 8 && k < wr_addr_q.size(); k++) begin
      n_vec++;
      if (wr_addr_q[k] != ((k < 4) ? 12810 + k : 13450 + k - 4) || wr_data_q[k] != 16 + k || wr_cyc_q[k] != 3 + k) begin
        n_miss++;
        $display("FAIL rpost_write[%0d]: got addr %0d data %0d cyc %0d expected addr %0d data %0d cyc %0d",
                 k, wr_addr_q[k], wr_data_q[k], wr_cyc_q[k], (k < 4) ? 12810 + k : 13450 + k - 4, 16 + k, 3 + k);
      end
    end
    n_vec++; if (done_first != 11) begin n_miss++; $display("FAIL rpost_done: got cycle %0d expected 11", done_first); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 8'(i);
    test_reset();
    test_basic();
    test_colour_key();
    test_clipping();
    test_edges();
    test_ignored_start();
    test_zero_size();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
